// File: rtl/rbus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rbus_arbiter_pkg
// Shared definitions for the two-requester line-read bus arbiter:
//   - arbitration FSM state encoding (IDLE / WAIT_I / WAIT_D)
//   - requester identifiers (REQ_I = ICache, REQ_D = DCache)
//   - default address / line widths and the read-enable width
// -----------------------------------------------------------------------------
package rbus_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;
  localparam int REN_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

endpackage

// File: rtl/rbus_req_slot.sv
// -----------------------------------------------------------------------------
// rbus_req_slot
// One-deep pending-request buffer for a single requester.
// Ports:
//   cpu_clk, cpu_rst : clock, asynchronous active-high reset
//   rrdy_i           : requester handshake ready (buffer may capture)
//   ren_i, raddr_i   : incoming read-enable pulse and line address
//   clear_i          : request has been granted; free the slot
//   pend_v_o         : a request is buffered
//   ren_o, addr_o    : buffered read enable and address
// -----------------------------------------------------------------------------
module rbus_req_slot
  import rbus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              rrdy_i,
  input  logic [REN_W-1:0]  ren_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              clear_i,
  output logic              pend_v_o,
  output logic [REN_W-1:0]  ren_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              pend_v_q, pend_v_d;
  logic [REN_W-1:0]  ren_q, ren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // A request while not ready is a protocol violation and simply dropped.
  // rrdy_i is low whenever the slot is full, so capture and clear never
  // coincide; capture still takes precedence for clarity.
  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    pend_v_d = pend_v_q;
    ren_d    = ren_q;
    addr_d   = addr_q;
    if (rrdy_i && (ren_i != '0)) begin
      pend_v_d = 1'b1;
      ren_d    = ren_i;
      addr_d   = raddr_i;
    end else if (clear_i) begin
      pend_v_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      pend_v_q <= 1'b0;
      ren_q    <= '0;
      addr_q   <= '0;
    end else begin
      pend_v_q <= pend_v_d;
      ren_q    <= ren_d;
      addr_q   <= addr_d;
    end
  end

  assign pend_v_o = pend_v_q;
  assign ren_o    = ren_q;
  assign addr_o   = addr_q;

endmodule

// File: rtl/rbus_arbiter.sv
// -----------------------------------------------------------------------------
// rbus_arbiter
// Shares one line-read device between ICache and DCache. Each requester gets a
// one-deep pending slot; one device transaction is in flight at a time and its
// response is steered back to the requester that owns it.
// Ports:
//   cpu_clk, cpu_rst                    : clock, asynchronous active-high reset
//   ic_rrdy/ic_ren/ic_raddr             : ICache request handshake
//   ic_rvalid/ic_rdata                  : ICache response (one-cycle pulse)
//   dc_rrdy/dc_ren/dc_raddr             : DCache request handshake
//   dc_rvalid/dc_rdata                  : DCache response (one-cycle pulse)
//   dev_rrdy/dev_ren/dev_raddr          : device request side
//   dev_rvalid/dev_rdata                : device response side
// RR_EN = 1 alternates on contention; RR_EN = 0 always favours DCache.
// -----------------------------------------------------------------------------
module rbus_arbiter
  import rbus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  output logic              ic_rrdy,
  input  logic [REN_W-1:0]  ic_ren,
  input  logic [ADDR_W-1:0] ic_raddr,
  output logic              ic_rvalid,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              dc_rrdy,
  input  logic [REN_W-1:0]  dc_ren,
  input  logic [ADDR_W-1:0] dc_raddr,
  output logic              dc_rvalid,
  output logic [LINE_W-1:0] dc_rdata,
  input  logic              dev_rrdy,
  output logic [REN_W-1:0]  dev_ren,
  output logic [ADDR_W-1:0] dev_raddr,
  input  logic              dev_rvalid,
  input  logic [LINE_W-1:0] dev_rdata
);

  state_e            state_q, state_d;
  req_id_e           last_grant_q, last_grant_d, win;
  logic [REN_W-1:0]  dev_ren_q, dev_ren_d;
  logic [ADDR_W-1:0] dev_raddr_q, dev_raddr_d;
  logic              ic_rvalid_q, ic_rvalid_d, dc_rvalid_q, dc_rvalid_d;
  logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d, dc_rdata_q, dc_rdata_d;

  logic              ic_pend_v, dc_pend_v, ic_clear, dc_clear;
  logic [REN_W-1:0]  ic_pend_ren, dc_pend_ren;
  logic [ADDR_W-1:0] ic_pend_addr, dc_pend_addr;

  // A requester is blocked while its slot is full or its own read is in
  // flight; the other requester's transaction does not block it.
  assign ic_rrdy = ~ic_pend_v & (state_q != WAIT_I);
  assign dc_rrdy = ~dc_pend_v & (state_q != WAIT_D);

  rbus_req_slot #(.ADDR_W(ADDR_W)) u_ic_slot (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .rrdy_i  (ic_rrdy),
    .ren_i   (ic_ren),
    .raddr_i (ic_raddr),
    .clear_i (ic_clear),
    .pend_v_o(ic_pend_v),
    .ren_o   (ic_pend_ren),
    .addr_o  (ic_pend_addr)
  );

  rbus_req_slot #(.ADDR_W(ADDR_W)) u_dc_slot (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .rrdy_i  (dc_rrdy),
    .ren_i   (dc_ren),
    .raddr_i (dc_raddr),
    .clear_i (dc_clear),
    .pend_v_o(dc_pend_v),
    .ren_o   (dc_pend_ren),
    .addr_o  (dc_pend_addr)
  );

  // Winner selection; only meaningful when at least one slot is pending.
  always_comb begin
    if (ic_pend_v && dc_pend_v) begin
      if (RR_EN) win = (last_grant_q == REQ_D) ? REQ_I : REQ_D;
      else       win = REQ_D;
    end else if (dc_pend_v) begin
      win = REQ_D;
    end else begin
      win = REQ_I;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    dev_ren_d    = '0;          // one-cycle pulse unless re-armed below
    dev_raddr_d  = dev_raddr_q; // address holds until the next grant
    ic_rvalid_d  = 1'b0;
    dc_rvalid_d  = 1'b0;
    ic_rdata_d   = ic_rdata_q;
    dc_rdata_d   = dc_rdata_q;
    ic_clear     = 1'b0;
    dc_clear     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // dev_rvalid here is spurious and deliberately not looked at.
        if (dev_rrdy && (ic_pend_v || dc_pend_v)) begin
          last_grant_d = win;
          if (win == REQ_I) begin
            dev_ren_d   = ic_pend_ren;
            dev_raddr_d = ic_pend_addr;
            ic_clear    = 1'b1;
            state_d     = WAIT_I;
          end else begin
            dev_ren_d   = dc_pend_ren;
            dev_raddr_d = dc_pend_addr;
            dc_clear    = 1'b1;
            state_d     = WAIT_D;
          end
        end
      end
      WAIT_I: begin
        if (dev_rvalid) begin
          ic_rvalid_d = 1'b1;
          ic_rdata_d  = dev_rdata;
          state_d     = IDLE;
        end
      end
      WAIT_D: begin
        if (dev_rvalid) begin
          dc_rvalid_d = 1'b1;
          dc_rdata_d  = dev_rdata;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_D;   // ICache wins the first tie
      dev_ren_q    <= '0;
      dev_raddr_q  <= '0;
      ic_rvalid_q  <= 1'b0;
      dc_rvalid_q  <= 1'b0;
      // NOTE: the wide data holding registers are reset as well: they drive
      // outputs directly and must read 0 after reset, not stale line data.
      ic_rdata_q   <= '0;
      dc_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      dev_ren_q    <= dev_ren_d;
      dev_raddr_q  <= dev_raddr_d;
      ic_rvalid_q  <= ic_rvalid_d;
      dc_rvalid_q  <= dc_rvalid_d;
      ic_rdata_q   <= ic_rdata_d;
      dc_rdata_q   <= dc_rdata_d;
    end
  end

  assign dev_ren   = dev_ren_q;
  assign dev_raddr = dev_raddr_q;
  assign ic_rvalid = ic_rvalid_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rvalid = dc_rvalid_q;
  assign dc_rdata  = dc_rdata_q;

endmodule
